// File: rtl/pipe_reg_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer.
// Both the data path and in_ready are registered.
module pipe_reg_skid #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_fire, out_fire;

  assign in_fire   = in_valid & rdy_q;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = rdy_q;
  assign q         = main_q;
  assign occ       = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = INIT;
      skid_d  = INIT;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = d;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = d;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = d;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can happen
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= INIT;
      skid_q  <= INIT;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule
